// File: rtl/risc_test_monitor_pkg.sv
// Shared parameters and state encoding for the RISC test monitor.
// Imported by the expected-write-back table and the monitor top.
package risc_test_monitor_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 3;
  localparam int DEF_N_CHK   = 8;
  localparam int DEF_RST_CYC = 4;
  localparam int DEF_TO_W    = 16;
  localparam int ERR_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESET_DUT = 2'd1,
    S_RUN       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  // Index width that never collapses to zero bits, even when the table has one entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tm_expect_table.sv
// Expected write-back table: one synchronous write port and one asynchronous read port.
// Not reset; the monitor only loads it while idle.
module tm_expect_table
  import risc_test_monitor_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int N_CHK   = DEF_N_CHK
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [idx_w(N_CHK)-1:0]   widx,
  input  logic [RADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [idx_w(N_CHK)-1:0]   ridx,
  output logic [RADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [RADDR_W-1:0] addr_mem [N_CHK];
  logic [DATA_W-1:0]  data_mem [N_CHK];

  always_ff @(posedge clk) begin
    if (we) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  assign raddr = addr_mem[ridx];
  assign rdata = data_mem[ridx];

endmodule

// File: rtl/risc_test_monitor.sv
// Test monitor: resets a processor under test, then checks its register write-backs
// against an expected table, with optional run-cycle timeout.
//
// state       | meaning
// S_IDLE      | waiting for start, dut held in reset, table writable
// S_RESET_DUT | dut_rst pulse of RST_CYC cycles
// S_RUN       | comparing write-backs, counting cycles
// S_DONE      | results held, table writable, waiting for start
module risc_test_monitor
  import risc_test_monitor_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int N_CHK   = DEF_N_CHK,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TO_W-1:0]         timeout_cycles,
  input  logic                    exp_we,
  input  logic [idx_w(N_CHK)-1:0] exp_idx,
  input  logic [RADDR_W-1:0]      exp_addr,
  input  logic [DATA_W-1:0]       exp_data,
  input  logic                    wb_valid,
  input  logic [RADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    dut_rst,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [idx_w(N_CHK)-1:0] first_fail_idx,
  output logic [TO_W-1:0]         cycle_count
);

  localparam int IDX_W = idx_w(N_CHK);
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHK - 1);

  state_t            state, state_nx;
  logic [RST_W-1:0]  rst_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [RADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              tbl_we, match, last_cmp, to_hit, can_load;

  assign can_load = (state == S_IDLE) || (state == S_DONE);
  assign tbl_we   = exp_we && can_load && (32'(exp_idx) < N_CHK);

  tm_expect_table #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .N_CHK   (N_CHK)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .widx  (exp_idx),
    .waddr (exp_addr),
    .wdata (exp_data),
    .ridx  (ptr),
    .raddr (tbl_addr),
    .rdata (tbl_data)
  );

  assign match    = (wb_addr == tbl_addr) && (wb_data == tbl_data);
  assign last_cmp = wb_valid && (ptr == LAST_IDX);
  assign to_hit   = (timeout_cycles != '0) && (cycle_count == timeout_cycles - TO_W'(1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RESET_DUT;
      S_RESET_DUT:    if (rst_cnt == '0) state_nx = S_RUN;
      S_RUN:          if (last_cmp || to_hit) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      rst_cnt        <= '0;
      ptr            <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      cycle_count    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt        <= RST_LOAD;
            ptr            <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
          end
        end
        S_RESET_DUT: begin
          if (rst_cnt != '0) rst_cnt <= rst_cnt - RST_W'(1);
        end
        S_RUN: begin
          if (wb_valid) begin
            ptr <= last_cmp ? '0 : ptr + IDX_W'(1);
            if (!match) begin
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              if (err_count == '0) first_fail_idx <= ptr;
            end
            if (last_cmp) pass <= match && (err_count == '0);
          end
          // A final compare in the timeout cycle wins over the timeout.
          if (to_hit && !last_cmp) timeout <= 1'b1;
          if (state_nx == S_RUN && cycle_count != '1) cycle_count <= cycle_count + TO_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dut_rst = (state == S_IDLE) || (state == S_RESET_DUT);
  assign busy    = (state == S_RESET_DUT) || (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_risc_test_monitor.sv
// Bench for risc_test_monitor: directed scenarios plus randomized runs, each checked
// against a per-run reference model that walks the write-back stream cycle by cycle.
module tb_risc_test_monitor;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int N_CHK   = 4;
  localparam int RST_CYC = 4;
  localparam int TO_W    = 16;
  localparam int MAXC    = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [TO_W-1:0]     timeout_cycles = '0;
  logic                exp_we = 1'b0;
  logic [1:0]          exp_idx = '0;
  logic [RADDR_W-1:0]  exp_addr = '0;
  logic [DATA_W-1:0]   exp_data = '0;
  logic                wb_valid = 1'b0;
  logic [RADDR_W-1:0]  wb_addr = '0;
  logic [DATA_W-1:0]   wb_data = '0;
  logic                dut_rst, busy, done, pass, timeout;
  logic [7:0]          err_count;
  logic [1:0]          first_fail_idx;
  logic [TO_W-1:0]     cycle_count;

  always #5 clk = ~clk;

  risc_test_monitor #(
    .DATA_W (DATA_W), .RADDR_W (RADDR_W), .N_CHK (N_CHK), .RST_CYC (RST_CYC), .TO_W (TO_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .timeout_cycles (timeout_cycles),
    .exp_we (exp_we), .exp_idx (exp_idx), .exp_addr (exp_addr), .exp_data (exp_data),
    .wb_valid (wb_valid), .wb_addr (wb_addr), .wb_data (wb_data),
    .dut_rst (dut_rst), .busy (busy), .done (done), .pass (pass), .timeout (timeout),
    .err_count (err_count), .first_fail_idx (first_fail_idx), .cycle_count (cycle_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [RADDR_W-1:0] m_addr [N_CHK];
  logic [DATA_W-1:0]  m_data [N_CHK];
  logic               wb_v [MAXC];
  logic [RADDR_W-1:0] wb_a [MAXC];
  logic [DATA_W-1:0]  wb_d [MAXC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_table(input int idx, input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0;
    m_addr[idx] = a;
    m_data[idx] = d;
  endtask

  task automatic load_ref_table();
    write_table(0, 3'd1, 16'h0005);
    write_table(1, 3'd2, 16'h000A);
    write_table(2, 3'd3, 16'h000F);
    write_table(3, 3'd1, 16'h0000);
  endtask

  task automatic clear_stream();
    for (int c = 0; c < MAXC; c++) begin
      wb_v[c] = 1'b0;
      wb_a[c] = RADDR_W'($urandom);
      wb_d[c] = DATA_W'($urandom);
    end
  endtask

  task automatic put_wb(input int c, input int k);
    wb_v[c] = 1'b1;
    wb_a[c] = m_addr[k];
    wb_d[c] = m_data[k];
  endtask

  // Start a run, replay the stream, and compare the outcome with the model.
  task automatic run_case(input string name, input int tmo, input bit noise);
    int k = 0, err = 0, ff = 0, endc = -1;
    bit to_exp = 0, pass_exp = 0;
    int rcnt = 0, ncyc = 0;
    for (int c = 0; c < MAXC && endc < 0; c++) begin
      if (wb_v[c]) begin
        if (wb_a[c] !== m_addr[k] || wb_d[c] !== m_data[k]) begin
          if (err == 0) ff = k;
          if (err < 255) err++;
        end
        k++;
        if (k == N_CHK) begin
          endc = c;
          pass_exp = (err == 0);
        end
      end
      if (endc < 0 && tmo != 0 && c == tmo - 1) begin
        endc = c;
        to_exp = 1;
      end
    end

    timeout_cycles = TO_W'(tmo);
    start = 1'b1;
    step();
    start = 1'b0;
    while (dut_rst === 1'b1 && rcnt < 20) begin
      if (noise) begin
        wb_valid = 1'b1; wb_addr = RADDR_W'($urandom); wb_data = DATA_W'($urandom);
        exp_we = 1'b1; exp_idx = 2'($urandom); exp_addr = RADDR_W'($urandom);
        exp_data = DATA_W'($urandom); start = 1'($urandom);
      end
      step();
      rcnt++;
    end
    wb_valid = 1'b0; exp_we = 1'b0; start = 1'b0;
    check({name, ".rst_len"}, rcnt, RST_CYC);
    check({name, ".busy_run"}, busy, 1);

    while (done !== 1'b1 && ncyc < MAXC + 8) begin
      if (ncyc < MAXC) begin
        wb_valid = wb_v[ncyc]; wb_addr = wb_a[ncyc]; wb_data = wb_d[ncyc];
      end else begin
        wb_valid = 1'b0;
      end
      if (noise) begin
        exp_we = 1'b1; exp_idx = 2'($urandom); exp_addr = RADDR_W'($urandom);
        exp_data = DATA_W'($urandom); start = 1'($urandom);
      end
      step();
      ncyc++;
    end
    wb_valid = 1'b0; exp_we = 1'b0; start = 1'b0;

    check({name, ".run_len"}, ncyc, endc + 1);
    check({name, ".done"}, done, 1);
    check({name, ".busy"}, busy, 0);
    check({name, ".pass"}, pass, pass_exp);
    check({name, ".timeout"}, timeout, to_exp);
    check({name, ".err_count"}, err_count, err);
    check({name, ".first_fail_idx"}, first_fail_idx, ff);
    check({name, ".cycle_count"}, cycle_count, endc);

    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = RADDR_W'($urandom); wb_data = DATA_W'($urandom);
      step();
    end
    wb_valid = 1'b0;
    check({name, ".hold_done"}, done, 1);
    check({name, ".hold_pass"}, pass, pass_exp);
    check({name, ".hold_err"}, err_count, err);
    check({name, ".hold_cyc"}, cycle_count, endc);
  endtask

  initial begin
    int kk;
    int tmo;
    repeat (3) step();
    check("rst.dut_rst", dut_rst, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.timeout", timeout, 0);
    check("rst.err_count", err_count, 0);
    check("rst.first_fail_idx", first_fail_idx, 0);
    check("rst.cycle_count", cycle_count, 0);
    rst = 1'b0;
    step();
    check("idle.dut_rst", dut_rst, 1);

    load_ref_table();

    clear_stream();
    put_wb(2, 0); put_wb(5, 1); put_wb(6, 2); put_wb(9, 3);
    run_case("all_match", 0, 1'b1);

    clear_stream();
    put_wb(1, 0); put_wb(2, 1); put_wb(4, 2); put_wb(7, 3);
    wb_d[4] = 16'h000E;
    run_case("one_bad", 0, 1'b0);

    clear_stream();
    put_wb(2, 0); put_wb(5, 1);
    run_case("timeout20", 20, 1'b0);

    clear_stream();
    put_wb(3, 0); put_wb(7, 1); put_wb(11, 2); put_wb(19, 3);
    run_case("final_at_to", 20, 1'b0);

    // Asynchronous reset in the middle of a run.
    clear_stream();
    timeout_cycles = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (RST_CYC + 2) step();
    check("abort.in_run", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort.dut_rst", dut_rst, 1);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.pass", pass, 0);
    check("abort.timeout", timeout, 0);
    check("abort.cycle_count", cycle_count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort.no_done", done, 0);
    end
    rst = 1'b0;
    step();
    load_ref_table();
    put_wb(0, 0); put_wb(1, 1); put_wb(2, 2); put_wb(3, 3);
    run_case("after_abort", 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N_CHK; i++) write_table(i, RADDR_W'($urandom), DATA_W'($urandom));
      clear_stream();
      kk = 0;
      for (int c = 0; c < MAXC; c++) begin
        if ($urandom_range(2, 0) == 0 || c >= MAXC - N_CHK) begin
          wb_v[c] = 1'b1;
          if (kk < N_CHK) begin
            wb_a[c] = m_addr[kk];
            wb_d[c] = m_data[kk];
            if ($urandom_range(3, 0) == 0) wb_d[c] = wb_d[c] ^ DATA_W'(1 << $urandom_range(DATA_W - 1, 0));
            if ($urandom_range(7, 0) == 0) wb_a[c] = wb_a[c] + 3'd1;
          end
          kk++;
        end
      end
      tmo = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(40, 3));
      run_case($sformatf("rand%0d", r), tmo, 1'(r % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
